weight_stream_reader: RTL and testbench

- Initiator for the single-port weight RAM read interface (ram_enable / o_data / o_valid handshake).
- On a start command it sweeps a contiguous address range and issues one read per word.
- Returned words are collected in a small credit-controlled FIFO and streamed to the neuron/MAC datapath with valid/ready backpressure.
- Sits between the layer controller, which issues start, base and length, and one hidden-layer weight RAM.

---
 rtl/weight_stream_reader_pkg.sv | 23 ++
 rtl/weight_stream_reader_sync_fifo.sv | 65 ++++++
 rtl/weight_stream_reader.sv | 152 +++++++++++++++
 tb/tb_weight_stream_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_stream_reader_pkg.sv
// Shared definitions for the weight RAM stream reader and its response FIFO.
package weight_stream_reader_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_BITS  = 5;
  localparam int DEF_LEN_BITS   = 6;
  localparam int DEF_FIFO_DEPTH = 4;

  // RAM read latency in cycles; the FIFO needs at least this many entries plus one.
  localparam int RAM_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wsr_state_e;

  function automatic int min_fifo_depth();
    return RAM_RD_LATENCY + 1;
  endfunction

endpackage

// File: rtl/weight_stream_reader_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo
  import weight_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; readers only look at it while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/weight_stream_reader.sv
// Sweeps a contiguous weight RAM range and streams the returned words downstream,
// issuing reads only while in-flight plus buffered words leave room in the FIFO.
//
// state    | meaning
// IDLE     | waiting for start; captures base and length
// ISSUE    | issuing reads while credit is available
// DRAIN    | all reads issued; waiting for responses and the final pop
// DONE     | one-cycle done pulse, still busy
module weight_stream_reader
  import weight_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int LEN_BITS   = DEF_LEN_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_BITS-1:0]  i_base_addr,
  input  logic [LEN_BITS-1:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_ram_enable,
  output logic                  o_ram_write_enable,
  output logic [ADDR_BITS-1:0]  o_ram_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  input  logic                  i_ram_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  input  logic                  i_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);

  wsr_state_e           state_q, state_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [LEN_BITS-1:0]  issued_q, issued_d;
  logic [LEN_BITS-1:0]  popped_q, popped_d;
  logic [CNT_W-1:0]     outst_q, outst_d;

  logic                  issue;
  logic                  ram_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W:0]        in_flight;
  logic                  credit_ok;

  assign in_flight = {1'b0, outst_q} + {1'b0, fifo_count};
  assign credit_ok = (in_flight < DEPTH_L);
  // Responses with nothing outstanding are strays or survivors of a reset.
  assign ram_push  = i_ram_valid && (outst_q != '0);
  assign fifo_pop  = !fifo_empty && i_ready;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q + LEN_BITS'(fifo_pop);
    issue    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          base_d   = i_base_addr;
          len_d    = i_length;
          issued_d = '0;
          popped_d = '0;
          state_d  = (i_length == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if ((issued_q != len_q) && credit_ok) begin
          issue    = 1'b1;
          issued_d = issued_q + 1'b1;
        end
        if (issued_d == len_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Counting the pop in progress lets done follow the last pop by one cycle.
        if ((outst_q == '0) && (popped_d == len_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    outst_d = outst_q + CNT_W'(issue) - CNT_W'(ram_push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      outst_q  <= outst_d;
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ram_push),
    .data_i  (i_ram_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_busy             = (state_q != ST_IDLE);
  assign o_done             = (state_q == ST_DONE);
  assign o_ram_enable       = issue;
  assign o_ram_write_enable = 1'b0;
  assign o_ram_addr         = issue ? (base_q + ADDR_BITS'(issued_q)) : '0;
  assign o_valid            = !fifo_empty;
  assign o_data             = fifo_empty ? '0 : fifo_head;
  assign o_last             = !fifo_empty && (({1'b0, popped_q} + 1'b1) == {1'b0, len_q});

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(ram_push && fifo_full && !fifo_pop));

  a_depth_ok : assert property (@(posedge clk) FIFO_DEPTH >= min_fifo_depth());

endmodule

// File: tb/tb_weight_stream_reader.sv
// Directed bench for weight_stream_reader with a two-cycle-latency RAM model.
module tb_weight_stream_reader;

  localparam int DW = 32;
  localparam int AB = 5;
  localparam int LB = 6;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [AB-1:0] i_base_addr;
  logic [LB-1:0] i_length;
  logic          o_busy, o_done, o_ram_enable, o_ram_write_enable;
  logic [AB-1:0] o_ram_addr;
  logic [DW-1:0] i_ram_data;
  logic          i_ram_valid;
  logic [DW-1:0] o_data;
  logic          o_valid, o_last;
  logic          i_ready;

  always #5 clk = ~clk;

  weight_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_BITS  (AB),
    .LEN_BITS   (LB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_start            (i_start),
    .i_base_addr        (i_base_addr),
    .i_length           (i_length),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_ram_enable       (o_ram_enable),
    .o_ram_write_enable (o_ram_write_enable),
    .o_ram_addr         (o_ram_addr),
    .i_ram_data         (i_ram_data),
    .i_ram_valid        (i_ram_valid),
    .o_data             (o_data),
    .o_valid            (o_valid),
    .o_last             (o_last),
    .i_ready            (i_ready)
  );

  // RAM model: word at address a holds 0x10 + a; valid two cycles after enable.
  logic [DW-1:0] ram_mem [32];
  logic          v1 = 1'b0, v2 = 1'b0;
  logic [AB-1:0] a1 = '0;
  logic [DW-1:0] d2 = '0;
  logic          stray_valid = 1'b0;

  always @(posedge clk) begin
    v1 <= o_ram_enable;
    a1 <= o_ram_addr;
    v2 <= v1;
    d2 <= ram_mem[a1];
  end

  assign i_ram_valid = v2 | stray_valid;
  assign i_ram_data  = stray_valid ? 32'hDEAD_BEEF : d2;

  // Monitor
  int          cyc = 0;
  int          addr_q[$];
  int          en_cyc_q[$];
  int          pop_cyc_q[$];
  logic [31:0] data_q[$];
  logic        last_q[$];
  int          done_cnt = 0, busy_cnt = 0, valid_cnt = 0, we_cnt = 0, done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_ram_enable) begin
      addr_q.push_back(int'(o_ram_addr));
      en_cyc_q.push_back(cyc);
    end
    if (o_valid) valid_cnt++;
    if (o_valid && i_ready) begin
      data_q.push_back(o_data);
      last_q.push_back(o_last);
      pop_cyc_q.push_back(cyc);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_busy) busy_cnt++;
    if (o_ram_write_enable) we_cnt++;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    addr_q.delete();
    en_cyc_q.delete();
    pop_cyc_q.delete();
    data_q.delete();
    last_q.delete();
    done_cnt  = 0;
    busy_cnt  = 0;
    valid_cnt = 0;
    done_cyc  = 0;
  endtask

  task automatic start_xfer(input int base, input int len);
    @(posedge clk);
    #1;
    i_start     = 1'b1;
    i_base_addr = AB'(base);
    i_length    = LB'(len);
    @(posedge clk);
    #1;
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit seen = 1'b0;
    for (int n = 0; n < maxc && !seen; n++) begin
      sample();
      if (o_done) seen = 1'b1;
    end
    chk({tag, " done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int base, input int len);
    chk({tag, " word count"}, data_q.size(), len);
    chk({tag, " issue count"}, addr_q.size(), len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % 32;
      chk({tag, " addr"}, (i < addr_q.size()) ? addr_q[i] : -1, a);
      chk({tag, " data"}, (i < data_q.size()) ? data_q[i] : 32'hBAD0_BAD0, 32'h10 + a);
      chk({tag, " last"}, (i < last_q.size()) ? 32'(last_q[i]) : 32'hF, (i == len - 1) ? 1 : 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " ctrl"}, {26'd0, o_busy, o_done, o_ram_enable, o_ram_write_enable, o_valid, o_last}, 32'd0);
    chk({tag, " addr"}, o_ram_addr, 32'd0);
    chk({tag, " data"}, o_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) ram_mem[i] = 32'h10 + i;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_base_addr = '0;
    i_length    = '0;
    i_ready     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    sample();
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic: base 0, length 4, ready held high
    clear_mon();
    start_xfer(0, 4);
    wait_done("basic", 40);
    check_stream("basic", 0, 4);
    if (en_cyc_q.size() == 4 && pop_cyc_q.size() == 4) begin
      chk("basic issue back-to-back", en_cyc_q[3] - en_cyc_q[0], 3);
      chk("basic pop back-to-back", pop_cyc_q[3] - pop_cyc_q[0], 3);
      chk("basic done after last pop", done_cyc - pop_cyc_q[3], 1);
      chk("basic busy cycles", busy_cnt, done_cyc - en_cyc_q[0] + 1);
    end
    chk("basic done pulses", done_cnt, 1);

    // Backpressure: ready low for the first 8 cycles of a length-8 transfer
    sample();
    clear_mon();
    i_ready = 1'b0;
    start_xfer(4, 8);
    for (int k = 1; k <= 8; k++) begin
      sample();
      if (k >= 4) begin
        chk("bp valid held", 32'(o_valid), 32'd1);
        chk("bp data held", o_data, 32'h14);
      end
    end
    chk("bp issues at credit limit", addr_q.size(), 4);
    @(posedge clk);
    #1;
    i_ready = 1'b1;
    wait_done("bp", 60);
    check_stream("bp", 4, 8);

    // Address wrap
    sample();
    clear_mon();
    start_xfer(30, 4);
    wait_done("wrap", 40);
    check_stream("wrap", 30, 4);

    // Length zero
    sample();
    clear_mon();
    start_xfer(0, 0);
    repeat (4) sample();
    chk("len0 busy cycles", busy_cnt, 1);
    chk("len0 done pulses", done_cnt, 1);
    chk("len0 issues", addr_q.size(), 0);

    // Reset mid-transfer with responses in flight
    clear_mon();
    start_xfer(0, 8);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample();
    check_idle_outputs("mid-reset");
    repeat (4) sample();
    chk("mid-reset issues before abort", addr_q.size(), 2);
    chk("mid-reset late responses dropped", valid_cnt, 0);
    chk("mid-reset no done", done_cnt, 0);
    clear_mon();
    start_xfer(0, 2);
    wait_done("post-reset", 40);
    check_stream("post-reset", 0, 2);
    repeat (3) sample();
    chk("post-reset valid cycles", valid_cnt, 2);

    // Start while busy is ignored
    clear_mon();
    start_xfer(8, 4);
    @(posedge clk);
    #1;
    i_start     = 1'b1;
    i_base_addr = 5'd0;
    i_length    = 6'd1;
    @(posedge clk);
    #1;
    i_start     = 1'b0;
    wait_done("busy-start", 40);
    check_stream("busy-start", 8, 4);
    repeat (4) sample();
    chk("busy-start single done", done_cnt, 1);
    chk("busy-start idle after", 32'(o_busy), 32'd0);

    // Stray RAM valid while idle
    clear_mon();
    @(posedge clk);
    #1;
    stray_valid = 1'b1;
    @(posedge clk);
    #1;
    stray_valid = 1'b0;
    repeat (4) sample();
    chk("stray no stream valid", valid_cnt, 0);
    chk("stray stays idle", busy_cnt, 0);

    chk("write enable never asserted", we_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
